ball_scheduler: RTL and testbench
=================================

BALL_SCHEDULER -- requirements
Module: ball_scheduler

Interface
REQ-001 Parameter STEP, default 2: pixels moved per frame_tick by each active ball.
REQ-002 Parameter COOLDOWN, default 3: frame_ticks after an accepted shot during which further shots are refused.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 play_en  input  1  high while the game is in the play display state.
REQ-006 frame_tick  input  1  one-cycle pulse, once per displayed frame.
REQ-007 fire_req  input  1  one-cycle pulse requesting a new ball.
REQ-008 gun_dir  input  2  gun direction: 00 +x, 01 -y, 10 -x, 11 +y.
REQ-009 hit_clear  input  8  per-slot retire request from collision logic; bit i is slot i.
REQ-010 ball_x_vector  output  64  packed 8-bit x coordinates, slot 0 in bits [63:56], slot 7 in bits [7:0].
REQ-011 ball_y_vector  output  56  packed 7-bit y coordinates, slot 0 in bits [55:49], slot 7 in bits [6:0].
REQ-012 ball_active  output  8  per-slot occupancy.
REQ-013 fire_ack  output  1  one-cycle pulse; the request was accepted.
REQ-014 fire_drop  output  1  one-cycle pulse; the request was refused.

Function
REQ-015 Block manages 8 ball slots; each slot holds active bit, x[7:0], y[6:0], dir[1:0].
REQ-016 Inactive slot coordinates are parked at x=0, y=0, which is outside the play field.
REQ-017 Play field is x 10..150, y 10..110 inclusive; gun is fixed at (80,60).
REQ-018 On an accepted fire_req, the lowest-index free slot becomes active with dir=gun_dir.
REQ-019 Spawn positions by gun_dir: 00 (86,60); 01 (80,54); 10 (74,60); 11 (80,66).
REQ-020 fire_req is accepted when play_en=1, cooldown=0 and at least one slot is free; fire_ack pulses in the next cycle.
REQ-021 fire_req with play_en=1 and either cooldown>0 or all 8 slots active is refused; fire_drop pulses in the next cycle.
REQ-022 fire_req with play_en=0 is ignored: no ack, no drop.
REQ-023 fire_ack and fire_drop never assert in the same cycle.
REQ-024 An accepted shot loads cooldown=COOLDOWN; each frame_tick decrements a nonzero cooldown; cooldown saturates at 0.
REQ-025 On frame_tick, each active slot moves STEP pixels along its dir: 00 x+=STEP, 01 y-=STEP, 10 x-=STEP, 11 y+=STEP.
REQ-026 If the moved position would fall outside the play field, the slot is retired instead: active=0, coordinates parked.
REQ-027 Boundary test uses 9-bit x and 8-bit y intermediates so that no wrap-around occurs.
REQ-028 hit_clear[i]=1 retires slot i in that cycle; this takes priority over movement in the same cycle.
REQ-029 When fire_req and frame_tick coincide, the new ball appears at its spawn position unmoved; existing balls move.
REQ-030 Slot freeing is decided before allocation: a slot freed by hit_clear or boundary retire in cycle N is allocatable from cycle N+1.
REQ-031 When play_en=0, all slots are retired and cooldown is cleared on the next clock edge.
REQ-032 Output vectors, ball_active, fire_ack and fire_drop are registered; the position update is visible one cycle after the frame_tick edge.

Reset
REQ-033 While resetn=0, all slots are inactive at (0,0), cooldown=0, fire_ack=0, fire_drop=0, ball_x_vector=0, ball_y_vector=0 and ball_active=0, asynchronously.
REQ-034 Reset asserted mid-operation discards all balls and any pending ack or drop; the first edge after release behaves as a fresh start.

Verification
REQ-035 Single shot: play_en=1, gun_dir=00, fire_req pulse -> next cycle fire_ack=1, ball_active=8'h01, ball_x_vector[63:56]=86, ball_y_vector[55:49]=60.
REQ-036 Movement and retire: after REQ-035, issue 32 frame_ticks -> slot 0 x=150 after tick 32 with slot still active; tick 33 retires it -> ball_active=0, coordinates (0,0).
REQ-037 Cooldown: fire accepted, then fire_req after 2 frame_ticks -> fire_drop=1; after a 3rd frame_tick a fire_req -> fire_ack=1 in slot 1.
REQ-038 Full table: fill 8 slots (COOLDOWN=0) -> ball_active=8'hFF; 9th fire -> fire_drop; hit_clear=8'h08 with a simultaneous fire -> drop; next fire -> slot 3, fire_ack.
REQ-039 Coincidence: fire_req with frame_tick and slot 0 active at (90,60) dir 00 -> slot 0 at (92,60), slot 1 at spawn unmoved; hit_clear[0] with frame_tick -> slot 0 retired.
REQ-040 play_en drop and reset: with 3 balls active, play_en=0 -> ball_active=0 next cycle; assert resetn=0 mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ball_scheduler.sv
// Eight-slot ball table for the shooter game: allocates shots from the gun,
// moves active balls once per frame and retires them on hits or when they leave the field.
module ball_scheduler #(
  parameter int STEP     = 2,
  parameter int COOLDOWN = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        play_en,
  input  logic        frame_tick,
  input  logic        fire_req,
  input  logic [1:0]  gun_dir,
  input  logic [7:0]  hit_clear,
  output logic [63:0] ball_x_vector,
  output logic [55:0] ball_y_vector,
  output logic [7:0]  ball_active,
  output logic        fire_ack,
  output logic        fire_drop
);

  localparam int            CW      = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
  localparam logic [8:0]    STEP_X  = 9'(STEP);
  localparam logic [7:0]    STEP_Y  = 8'(STEP);

  function automatic logic [14:0] spawn_pos(input logic [1:0] d);
    logic [14:0] p;
    case (d)
      2'b00:   p = {8'd86, 7'd60};
      2'b01:   p = {8'd80, 7'd54};
      2'b10:   p = {8'd74, 7'd60};
      2'b11:   p = {8'd80, 7'd66};
      default: p = 15'd0;
    endcase
    return p;
  endfunction

  // Widened coordinates so a step past either edge cannot wrap back into the field.
  function automatic logic in_field(input logic [8:0] x, input logic [7:0] y);
    return (x >= 9'd10) && (x <= 9'd150) && (y >= 8'd10) && (y <= 8'd110);
  endfunction

  logic [7:0]    act_r;
  logic [7:0]    x_r   [8];
  logic [6:0]    y_r   [8];
  logic [1:0]    dir_r [8];
  logic [CW-1:0] cd_r;
  logic          ack_r;
  logic          drop_r;

  logic [7:0]    act_s;
  logic [7:0]    x_s   [8];
  logic [6:0]    y_s   [8];
  logic [1:0]    dir_s [8];
  logic [CW-1:0] cd_s;
  logic [8:0]    mx_s  [8];
  logic [7:0]    my_s  [8];
  logic [2:0]    free_slot_s;
  logic          any_free_s;
  logic          accept_s;
  logic          drop_s;
  logic [14:0]   spawn_s;

  // Candidate position of every slot after one step along its direction.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      mx_s[i] = {1'b0, x_r[i]};
      my_s[i] = {1'b0, y_r[i]};
      case (dir_r[i])
        2'b00:   mx_s[i] = {1'b0, x_r[i]} + STEP_X;
        2'b01:   my_s[i] = {1'b0, y_r[i]} - STEP_Y;
        2'b10:   mx_s[i] = {1'b0, x_r[i]} - STEP_X;
        2'b11:   my_s[i] = {1'b0, y_r[i]} + STEP_Y;
        default: mx_s[i] = {1'b0, x_r[i]};
      endcase
    end
  end

  // Shot arbitration against the occupancy held at the start of the cycle.
  always_comb begin
    free_slot_s = 3'd0;
    any_free_s  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!act_r[i]) begin
        free_slot_s = 3'(i);
        any_free_s  = 1'b1;
      end else begin
        any_free_s  = any_free_s;
      end
    end
    accept_s = play_en && fire_req && (cd_r == '0) && any_free_s;
    drop_s   = play_en && fire_req && !accept_s;
    spawn_s  = spawn_pos(gun_dir);
  end

  // Next slot table and cooldown: hit retire beats movement, new shot lands unmoved.
  always_comb begin
    act_s = act_r;
    x_s   = x_r;
    y_s   = y_r;
    dir_s = dir_r;
    cd_s  = cd_r;
    if (!play_en) begin
      act_s = 8'h00;
      cd_s  = '0;
      for (int i = 0; i < 8; i++) begin
        x_s[i] = 8'd0;
        y_s[i] = 7'd0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (hit_clear[i]) begin
          act_s[i] = 1'b0;
          x_s[i]   = 8'd0;
          y_s[i]   = 7'd0;
        end else if (act_r[i] && frame_tick) begin
          if (in_field(mx_s[i], my_s[i])) begin
            x_s[i] = mx_s[i][7:0];
            y_s[i] = my_s[i][6:0];
          end else begin
            act_s[i] = 1'b0;
            x_s[i]   = 8'd0;
            y_s[i]   = 7'd0;
          end
        end else begin
          act_s[i] = act_r[i];
        end
      end
      if (accept_s) begin
        act_s[free_slot_s] = 1'b1;
        x_s[free_slot_s]   = spawn_s[14:7];
        y_s[free_slot_s]   = spawn_s[6:0];
        dir_s[free_slot_s] = gun_dir;
        cd_s               = CD_LOAD;
      end else if (frame_tick && (cd_r != '0)) begin
        cd_s = cd_r - CW'(1);
      end else begin
        cd_s = cd_r;
      end
    end
  end

  // State and handshake registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      act_r  <= 8'h00;
      cd_r   <= '0;
      ack_r  <= 1'b0;
      drop_r <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        x_r[i]   <= 8'd0;
        y_r[i]   <= 7'd0;
        dir_r[i] <= 2'b00;
      end
    end else begin
      act_r  <= act_s;
      x_r    <= x_s;
      y_r    <= y_s;
      dir_r  <= dir_s;
      cd_r   <= cd_s;
      ack_r  <= accept_s;
      drop_r <= drop_s;
    end
  end

  assign ball_active = act_r;
  assign fire_ack    = ack_r;
  assign fire_drop   = drop_r;

  for (genvar g = 0; g < 8; g++) begin : g_pack
    assign ball_x_vector[63-8*g -: 8] = x_r[g];
    assign ball_y_vector[55-7*g -: 7] = y_r[g];
  end

endmodule

// File: tb/tb_ball_scheduler.sv
// Scoreboard bench for ball_scheduler: two instances (COOLDOWN=3 and COOLDOWN=0)
// share stimulus and are selected per phase by their own play_en.
module tb_ball_scheduler;

  logic        clock      = 1'b0;
  logic        resetn     = 1'b0;
  logic        play_en_a  = 1'b0;
  logic        play_en_b  = 1'b0;
  logic        frame_tick = 1'b0;
  logic        fire_req   = 1'b0;
  logic [1:0]  gun_dir    = 2'b00;
  logic [7:0]  hit_clear  = 8'h00;

  logic [63:0] bx_a, bx_b;
  logic [55:0] by_a, by_b;
  logic [7:0]  act_a, act_b;
  logic        ack_a, ack_b, drop_a, drop_b;

  ball_scheduler #(.STEP(2), .COOLDOWN(3)) dut_a (
    .clock(clock), .resetn(resetn), .play_en(play_en_a), .frame_tick(frame_tick),
    .fire_req(fire_req), .gun_dir(gun_dir), .hit_clear(hit_clear),
    .ball_x_vector(bx_a), .ball_y_vector(by_a), .ball_active(act_a),
    .fire_ack(ack_a), .fire_drop(drop_a)
  );

  ball_scheduler #(.STEP(2), .COOLDOWN(0)) dut_b (
    .clock(clock), .resetn(resetn), .play_en(play_en_b), .frame_tick(frame_tick),
    .fire_req(fire_req), .gun_dir(gun_dir), .hit_clear(hit_clear),
    .ball_x_vector(bx_b), .ball_y_vector(by_b), .ball_active(act_b),
    .fire_ack(ack_b), .fire_drop(drop_b)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       ack;
    logic [2:0] slot;
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] active;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [7:0] sx(input logic [63:0] v, input int s);
    return v[63-8*s -: 8];
  endfunction

  function automatic logic [6:0] sy(input logic [55:0] v, input int s);
    return v[55-7*s -: 7];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic expect_ack(input int w, input int s, input int x, input int y, input logic [7:0] a);
    exp_t e;
    e.ack = 1'b1; e.slot = 3'(s); e.x = 8'(x); e.y = 7'(y); e.active = a;
    if (w == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  task automatic expect_drop(input int w, input logic [7:0] a);
    exp_t e;
    e = '0;
    e.active = a;
    if (w == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  task automatic step(input logic f, input logic t, input logic [7:0] h);
    fire_req = f; frame_tick = t; hit_clear = h;
    @(negedge clock);
    fire_req = 1'b0; frame_tick = 1'b0; hit_clear = 8'h00;
  endtask

  task automatic mon(input int w, input logic ack, input logic drop, input logic [7:0] act,
                     input logic [63:0] bx, input logic [55:0] by);
    exp_t e;
    int   n;
    n = (w == 0) ? qa.size() : qb.size();
    if (ack || drop) begin
      total++;
      if (ack && drop) begin
        bad++;
        $display("FAIL resp_both dut%0d ack=1 drop=1", w);
      end else if (n == 0) begin
        bad++;
        $display("FAIL resp_unexpected dut%0d ack=%0b drop=%0b want none", w, ack, drop);
      end else begin
        if (w == 0) e = qa.pop_front(); else e = qb.pop_front();
        if (ack !== e.ack || act !== e.active ||
            (e.ack && (sx(bx, int'(e.slot)) !== e.x || sy(by, int'(e.slot)) !== e.y))) begin
          bad++;
          $display("FAIL resp_dut%0d got ack=%0b act=%0h x=%0d y=%0d want ack=%0b act=%0h slot=%0d x=%0d y=%0d",
                   w, ack, act, sx(bx, int'(e.slot)), sy(by, int'(e.slot)),
                   e.ack, e.active, e.slot, e.x, e.y);
        end
      end
    end
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      mon(0, ack_a, drop_a, act_a, bx_a, by_a);
      mon(1, ack_b, drop_b, act_b, bx_b, by_b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clock);
    chk("rst_active", {56'd0, act_a}, 64'h0);
    chk("rst_x", bx_a, 64'h0);
    chk("rst_y", {8'd0, by_a}, 64'h0);
    chk("rst_hs", {62'd0, ack_a, drop_a}, 64'h0);
    resetn = 1'b1;
    play_en_a = 1'b1;

    // single shot, then fly +x to the right edge and out
    gun_dir = 2'b00;
    expect_ack(0, 0, 86, 60, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    chk("shot_x", {56'd0, sx(bx_a, 0)}, 64'd86);
    chk("shot_y", {57'd0, sy(by_a, 0)}, 64'd60);
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 8'h00);
    chk("edge_x", {56'd0, sx(bx_a, 0)}, 64'd150);
    chk("edge_active", {56'd0, act_a}, 64'h01);
    step(1'b0, 1'b1, 8'h00);
    chk("out_active", {56'd0, act_a}, 64'h00);
    chk("out_x", {56'd0, sx(bx_a, 0)}, 64'd0);
    chk("out_y", {57'd0, sy(by_a, 0)}, 64'd0);

    // cooldown: 2 ticks still refuse, third tick re-arms
    gun_dir = 2'b01;
    expect_ack(0, 0, 80, 54, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    expect_drop(0, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    gun_dir = 2'b11;
    expect_ack(0, 1, 80, 66, 8'h03);
    step(1'b1, 1'b0, 8'h00);
    chk("cd_slot0_y", {57'd0, sy(by_a, 0)}, 64'd48);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h00);
    gun_dir = 2'b10;
    expect_ack(0, 2, 74, 60, 8'h07);
    step(1'b1, 1'b0, 8'h00);
    chk("three_y0", {57'd0, sy(by_a, 0)}, 64'd42);
    chk("three_y1", {57'd0, sy(by_a, 1)}, 64'd72);

    // leaving play clears everything; fire while not playing is ignored
    play_en_a = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    chk("noplay_active", {56'd0, act_a}, 64'h00);
    chk("noplay_x", bx_a, 64'h0);
    chk("noplay_y", {8'd0, by_a}, 64'h0);
    step(1'b1, 1'b0, 8'h00);
    chk("ignored_active", {56'd0, act_a}, 64'h00);

    // coincident fire and tick, then hit_clear beats movement
    play_en_b = 1'b1;
    gun_dir = 2'b00;
    expect_ack(1, 0, 86, 60, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("coin_pre_x", {56'd0, sx(bx_b, 0)}, 64'd90);
    gun_dir = 2'b11;
    expect_ack(1, 1, 80, 66, 8'h03);
    step(1'b1, 1'b1, 8'h00);
    chk("coin_moved_x", {56'd0, sx(bx_b, 0)}, 64'd92);
    chk("coin_moved_y", {57'd0, sy(by_b, 0)}, 64'd60);
    step(1'b0, 1'b1, 8'h01);
    chk("hit_active", {56'd0, act_b}, 64'h02);
    chk("hit_x", {56'd0, sx(bx_b, 0)}, 64'd0);
    chk("hit_y1", {57'd0, sy(by_b, 1)}, 64'd68);
    play_en_b = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    chk("b_clear", {56'd0, act_b}, 64'h00);
    play_en_b = 1'b1;

    // full table, refuse, freed slot only reusable the next cycle
    gun_dir = 2'b00;
    for (int s = 0; s < 8; s++) begin
      expect_ack(1, s, 86, 60, 8'((1 << (s + 1)) - 1));
      step(1'b1, 1'b0, 8'h00);
    end
    chk("full_active", {56'd0, act_b}, 64'hFF);
    expect_drop(1, 8'hFF);
    step(1'b1, 1'b0, 8'h00);
    expect_drop(1, 8'hF7);
    step(1'b1, 1'b0, 8'h08);
    expect_ack(1, 3, 86, 60, 8'hFF);
    step(1'b1, 1'b0, 8'h00);

    // asynchronous reset mid-cycle discards balls, cooldown and the pending ack
    play_en_b = 1'b0;
    play_en_a = 1'b1;
    gun_dir = 2'b00;
    expect_ack(0, 0, 86, 60, 8'h01);
    step(1'b1, 1'b0, 8'h00);
    fire_req = 1'b1;
    frame_tick = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("arst_active_a", {56'd0, act_a}, 64'h00);
    chk("arst_x_a", bx_a, 64'h0);
    chk("arst_y_a", {8'd0, by_a}, 64'h0);
    chk("arst_active_b", {56'd0, act_b}, 64'h00);
    @(negedge clock);
    chk("arst_hs", {62'd0, ack_a, drop_a}, 64'h0);
    fire_req = 1'b0;
    frame_tick = 1'b0;
    resetn = 1'b1;
    expect_ack(0, 0, 86, 60, 8'h01);
    step(1'b1, 1'b0, 8'h00);

    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("pending_a", 64'(qa.size()), 64'd0);
    chk("pending_b", 64'(qb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
